// File: rtl/dac_cfg_frame_loader_pkg.sv
// Shared types and helpers for the DAC configuration frame loader.
// Holds the loader FSM encoding and the frame payload length helper.
package dac_cfg_frame_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_e;

   // Payload length of one frame, start and parity bits excluded.
   function automatic int frame_bits(input int nch, input int w);
      return nch * w;
   endfunction

endpackage

// File: rtl/dac_cfg_frame_loader_shift.sv
// Enable-gated serial-in/parallel-out register with synchronous clear.
// New bits enter at the LSB, so the first bit shifted in ends up at the MSB.
module cfg_shift_reg #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         din_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] q_q;
   logic [N-1:0] q_d;
   logic [N:0]   ext;

   always_comb begin
      ext = {q_q, din_i};
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (en_i) begin
         q_d = ext[N-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/dac_cfg_frame_loader.sv
// Serial loader for DAC reference codes: parity-checked frames land in a
// staging register and are committed atomically to the shadow by `load`.
module dac_cfg_frame_loader
   import dac_cfg_frame_loader_pkg::*;
#(
   parameter int NCH = 3,
   parameter int W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sen,
   input  logic             sdi,
   input  logic             load,
   output logic [NCH*W-1:0] codes,
   output logic             pending,
   output logic             busy,
   output logic             frame_ok,
   output logic             frame_err
);

   localparam int F  = frame_bits(NCH, W);
   localparam int CW = $clog2(F + 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            par_q;
   logic [F-1:0]    stage_q;
   logic [F-1:0]    codes_q;
   logic            pending_q;
   logic            busy_q;
   logic            ok_q;
   logic            err_q;

   logic [F-1:0]    shift_w;
   logic            sh_clr;
   logic            sh_en;

   assign sh_clr = (state_q == ST_IDLE) && sen && sdi;
   assign sh_en  = (state_q == ST_SHIFT) && sen;

   cfg_shift_reg #(.N(F)) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (sh_clr),
      .en_i  (sh_en),
      .din_i (sdi),
      .q_o   (shift_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         par_q     <= 1'b0;
         stage_q   <= '0;
         codes_q   <= '0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ok_q  <= 1'b0;
         err_q <= 1'b0;

         // Commit uses the old staging; a frame finishing on the same edge
         // re-arms pending below, since the later assignment wins.
         if (load && pending_q) begin
            codes_q   <= stage_q;
            pending_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (sen && sdi) begin
                  cnt_q   <= '0;
                  par_q   <= 1'b0;
                  state_q <= ST_SHIFT;
                  busy_q  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (!sen) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  par_q <= par_q ^ sdi;
                  if (cnt_q != CW'(F)) begin
                     cnt_q <= cnt_q + CW'(1);
                  end
                  if (cnt_q == CW'(F - 1)) begin
                     state_q <= ST_PARITY;
                  end
               end
            end
            ST_PARITY: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (!sen) begin
                  err_q <= 1'b1;
               end else if (par_q == sdi) begin
                  stage_q   <= shift_w;
                  pending_q <= 1'b1;
                  ok_q      <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign codes     = codes_q;
   assign pending   = pending_q;
   assign busy      = busy_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_dac_cfg_frame_loader.sv
// Directed plus randomized bench for dac_cfg_frame_loader against a
// frame-level reference model (staging / pending / committed codes).
module tb_dac_cfg_frame_loader;

   localparam int NCH = 3;
   localparam int W   = 3;
   localparam int F   = NCH * W;

   logic         clk;
   logic         rst_n;
   logic         sen;
   logic         sdi;
   logic         load;
   logic [F-1:0] codes;
   logic         pending;
   logic         busy;
   logic         frame_ok;
   logic         frame_err;

   int n_vec;
   int n_err;

   logic [F-1:0] stage_m;
   logic [F-1:0] codes_m;
   logic         pending_m;

   dac_cfg_frame_loader #(.NCH(NCH), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sen       (sen),
      .sdi       (sdi),
      .load      (load),
      .codes     (codes),
      .pending   (pending),
      .busy      (busy),
      .frame_ok  (frame_ok),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic d, input logic l);
      @(negedge clk);
      sen  = s;
      sdi  = d;
      load = l;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic exp_ok, input logic exp_err,
                            input logic exp_busy);
      chk({tag, ".ok"}, 32'(frame_ok), 32'(exp_ok));
      chk({tag, ".err"}, 32'(frame_err), 32'(exp_err));
      chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
      chk({tag, ".pending"}, 32'(pending), 32'(pending_m));
      chk({tag, ".codes"}, 32'(codes), 32'(codes_m));
   endtask

   function automatic logic even_par(input logic [F-1:0] d);
      return logic'($countones(d) % 2);
   endfunction

   // abort_at: -1 = none, 0..F-1 = drop sen in place of that data bit,
   // F = drop sen in place of the parity bit.
   task automatic send_frame(input string tag, input logic [F-1:0] data, input logic par,
                             input logic load_last, input int abort_at);
      logic good;
      drive(1'b1, 1'b1, 1'b0);
      chk_state({tag, ".start"}, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < F; i++) begin
         if (i == abort_at) begin
            drive(1'b0, 1'b0, 1'b0);
            chk_state({tag, ".abort"}, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            chk_state({tag, ".after_abort"}, 1'b0, 1'b0, 1'b0);
            return;
         end
         drive(1'b1, data[F-1-i], 1'b0);
         chk_state({tag, ".bit"}, 1'b0, 1'b0, 1'b1);
      end
      if (abort_at == F) begin
         drive(1'b0, 1'b0, 1'b0);
         chk_state({tag, ".abort_par"}, 1'b0, 1'b1, 1'b0);
         return;
      end
      drive(1'b1, par, load_last);
      good = (even_par(data) == par);
      if (load_last && pending_m) begin
         codes_m   = stage_m;
         pending_m = 1'b0;
      end
      if (good) begin
         stage_m   = data;
         pending_m = 1'b1;
      end
      chk_state({tag, ".end"}, good, !good, 1'b0);
   endtask

   task automatic idle_load(input string tag, input logic l);
      drive(1'b0, 1'b0, l);
      if (l && pending_m) begin
         codes_m   = stage_m;
         pending_m = 1'b0;
      end
      chk_state(tag, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [F-1:0] d;
      logic         p;
      int           ab;
      n_vec     = 0;
      n_err     = 0;
      stage_m   = '0;
      codes_m   = '0;
      pending_m = 1'b0;
      sen       = 1'b0;
      sdi       = 1'b0;
      load      = 1'b0;
      rst_n     = 1'b0;

      // Reset held with toggling inputs.
      for (int i = 0; i < 6; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         chk_state("reset", 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle_load("post_reset", 1'b0);

      // Good frame, then commit.
      send_frame("good", 9'h15E, 1'b0, 1'b0, -1);
      chk("good.stage_codes_zero", 32'(codes), 32'h0);
      idle_load("good.load", 1'b1);
      chk("good.codes", 32'(codes), 32'h15E);

      // Bad parity.
      send_frame("badpar", 9'h15E, 1'b1, 1'b0, -1);
      chk("badpar.pending", 32'(pending), 32'h0);

      // Abort after 4 data bits, then a clean frame.
      send_frame("abort", 9'h0AA, 1'b0, 1'b0, 4);
      send_frame("post_abort", 9'h1C1, 1'b0, 1'b0, -1);
      idle_load("post_abort.load", 1'b1);
      chk("post_abort.codes", 32'(codes), 32'h1C1);

      // Abort in place of the parity bit.
      send_frame("abort_par", 9'h123, even_par(9'h123), 1'b0, F);

      // Simultaneous commit and frame completion.
      send_frame("simA", 9'h15E, 1'b0, 1'b0, -1);
      send_frame("simB", 9'h0C1, even_par(9'h0C1), 1'b1, -1);
      chk("sim.codes", 32'(codes), 32'h15E);
      chk("sim.pending", 32'(pending), 32'h1);
      idle_load("sim.load2", 1'b1);
      chk("sim.codes2", 32'(codes), 32'h0C1);

      // Back-to-back frames, then a load while nothing pending.
      send_frame("b2b0", 9'h0F0, even_par(9'h0F0), 1'b0, -1);
      send_frame("b2b1", 9'h00F, even_par(9'h00F), 1'b0, -1);
      idle_load("b2b.load", 1'b1);
      chk("b2b.codes", 32'(codes), 32'h00F);
      idle_load("idle_load", 1'b1);
      chk("idle_load.codes", 32'(codes), 32'h00F);

      // Randomized frames, aborts, parity errors and loads.
      for (int n = 0; n < 40; n++) begin
         d  = F'($urandom);
         p  = even_par(d) ^ ($urandom_range(0, 3) == 0);
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, F)) : -1;
         send_frame("rnd", d, p, 1'($urandom_range(0, 1)), ab);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            idle_load("rnd.gap", 1'($urandom_range(0, 1)));
         end
      end

      // Asynchronous reset mid-frame: everything cleared, no pulse.
      send_frame("pre_rst", 9'h1A5, even_par(9'h1A5), 1'b0, -1);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      stage_m   = '0;
      codes_m   = '0;
      pending_m = 1'b0;
      chk_state("async_rst", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_load("after_rst.load", 1'b1);
      send_frame("after_rst", 9'h155, even_par(9'h155), 1'b0, -1);
      idle_load("after_rst.commit", 1'b1);
      chk("after_rst.codes", 32'(codes), 32'h155);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
